// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage next-PC unit.
package pc_pkg;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        J_SEQ = 2'b00,
        J_JMP = 2'b01,
        J_JR  = 2'b10
    } jump_t;

    typedef enum logic [2:0] {
        B_NONE = 3'b000,
        B_EQ   = 3'b001,
        B_NE   = 3'b010,
        B_LEZ  = 3'b011,
        B_GTZ  = 3'b100,
        B_LTZ  = 3'b101,
        B_GEZ  = 3'b110
    } bop_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_WAIT  = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/f_branch_cmp.sv
// Combinational branch-taken evaluator. Sign-vs-zero branches exist only
// when BRANCH_ZERO_EN is defined; otherwise those codes are never taken.
module f_branch_cmp
    import pc_pkg::*;
#(
    parameter int PC_W = 32
)(
    input  logic [2:0]      i_bop,
    input  logic [PC_W-1:0] i_rs,
    input  logic [PC_W-1:0] i_rt,
    output logic            o_taken
);

`ifdef BRANCH_ZERO_EN
    logic signed [PC_W-1:0] w_rs_s;
    assign w_rs_s = i_rs;
`endif

    always_comb begin
        o_taken = 1'b0;
        case (i_bop)
            B_EQ:    o_taken = (i_rs == i_rt);
            B_NE:    o_taken = (i_rs != i_rt);
`ifdef BRANCH_ZERO_EN
            B_LEZ:   o_taken = (w_rs_s <= 0);
            B_GTZ:   o_taken = (w_rs_s > 0);
            B_LTZ:   o_taken = (w_rs_s < 0);
            B_GEZ:   o_taken = (w_rs_s >= 0);
`endif
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/f_pc_unit.sv
// Fetch-stage next-PC unit: owns the fetch PC, drives imem requests and
// resolves decode-stage jumps/branches. Optional macro: BRANCH_ZERO_EN.
module f_pc_unit
    import pc_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR
)(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    input  logic [1:0]      i_con_jump,
    input  logic [2:0]      i_con_bop,
    input  logic [PC_W-1:0] i_id_pc4,
    input  logic [15:0]     i_id_imm,
    input  logic [25:0]     i_id_index,
    input  logic [PC_W-1:0] i_id_rs,
    input  logic [PC_W-1:0] i_id_rt,
    input  logic            i_imem_ready,
    output logic            o_imem_req,
    output logic [PC_W-1:0] o_imem_addr,
    output logic [PC_W-1:0] o_pc4,
    output logic            o_flush,
    output logic            o_redirect
);

    fetch_state_t    r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic [PC_W-1:0] r_pc4, w_pc4_nxt;
    logic            r_flush;
    logic            r_pending, w_pending_nxt;
    logic [PC_W-1:0] r_pend_tgt, w_pend_tgt_nxt;

    logic            w_taken;
    logic            w_redirect;
    logic            w_req;
    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_br_tgt;
    logic [PC_W-1:0] w_j_tgt;
    logic [PC_W-1:0] w_target;

    f_branch_cmp #(.PC_W(PC_W)) u_cmp (
        .i_bop   (i_con_bop),
        .i_rs    (i_id_rs),
        .i_rt    (i_id_rt),
        .o_taken (w_taken)
    );

    assign w_pc_plus4 = r_pc + PC_W'(4);
    assign w_br_tgt   = i_id_pc4 + {{(PC_W-18){i_id_imm[15]}}, i_id_imm, 2'b00};
    assign w_j_tgt    = {i_id_pc4[PC_W-1 -: 4], i_id_index, 2'b00};

    // jump code 11 falls through to the sequential/branch case
    always_comb begin
        w_target   = w_br_tgt;
        w_redirect = 1'b0;
        if (i_con_jump == J_JMP) begin
            w_target   = w_j_tgt;
            w_redirect = 1'b1;
        end else if (i_con_jump == J_JR) begin
            w_target   = i_id_rs;
            w_redirect = 1'b1;
        end else begin
            w_redirect = w_taken;
        end
        if (i_stall) w_redirect = 1'b0;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pc4_nxt      = r_pc4;
        w_pending_nxt  = r_pending;
        w_pend_tgt_nxt = r_pend_tgt;
        w_req          = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
                if (w_redirect) w_pc_nxt = w_target;
            end
            S_FETCH: begin
                w_req = ~i_stall;
                if (w_req && i_imem_ready) begin
                    w_pc4_nxt = w_pc_plus4;
                    w_pc_nxt  = w_redirect ? w_target : w_pc_plus4;
                end else if (w_req) begin
                    w_state_nxt = S_WAIT;
                    if (w_redirect) w_pc_nxt = w_target;
                end
            end
            S_WAIT: begin
                // address must stay put until imem takes it; redirects are parked
                w_req = 1'b1;
                if (i_imem_ready) begin
                    w_pc4_nxt     = w_pc_plus4;
                    w_pc_nxt      = r_pending ? r_pend_tgt :
                                    (w_redirect ? w_target : w_pc_plus4);
                    w_pending_nxt = 1'b0;
                    w_state_nxt   = S_FETCH;
                end else if (w_redirect) begin
                    w_pending_nxt  = 1'b1;
                    w_pend_tgt_nxt = w_target;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_VECTOR;
            r_pc4     <= RESET_VECTOR + PC_W'(4);
            r_flush   <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_pc4     <= w_pc4_nxt;
            r_flush   <= w_redirect;
            r_pending <= w_pending_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        r_pend_tgt <= w_pend_tgt_nxt;
    end

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_pc;
    assign o_pc4       = r_pc4;
    assign o_flush     = r_flush;
    assign o_redirect  = w_redirect;

endmodule

// File: tb/tb_f_pc_unit.sv
// Self-checking bench for f_pc_unit: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_f_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [1:0]  con_jump;
    logic [2:0]  con_bop;
    logic [31:0] id_pc4;
    logic [15:0] id_imm;
    logic [25:0] id_index;
    logic [31:0] id_rs;
    logic [31:0] id_rt;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc4;
    logic        flush;
    logic        redirect;

    int n_total = 0;
    int n_pass  = 0;

`ifdef BRANCH_ZERO_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    f_pc_unit dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_stall      (stall),
        .i_con_jump   (con_jump),
        .i_con_bop    (con_bop),
        .i_id_pc4     (id_pc4),
        .i_id_imm     (id_imm),
        .i_id_index   (id_index),
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .i_imem_ready (imem_ready),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .o_pc4        (pc4),
        .o_flush      (flush),
        .o_redirect   (redirect)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // ---------------- behavioural model ----------------
    bit          m_valid = 0;
    bit          m_started;
    bit          m_outst;
    bit          m_pend;
    logic [31:0] m_ptgt;
    logic [31:0] m_pc;
    logic [31:0] m_pc4;
    bit          m_flush;

    function automatic bit m_taken(input logic [2:0] b, input logic [31:0] rs, input logic [31:0] rt);
        case (b)
            3'd1: return rs == rt;
            3'd2: return rs != rt;
            3'd3: return ZERO_EN && ($signed(rs) <= 0);
            3'd4: return ZERO_EN && ($signed(rs) > 0);
            3'd5: return ZERO_EN && ($signed(rs) < 0);
            3'd6: return ZERO_EN && ($signed(rs) >= 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_redir();
        if (stall) return 1'b0;
        if (con_jump == 2'b01 || con_jump == 2'b10) return 1'b1;
        return m_taken(con_bop, id_rs, id_rt);
    endfunction

    function automatic logic [31:0] m_target();
        logic [31:0] off;
        off = 32'($signed(id_imm)) * 4;
        if (con_jump == 2'b01) return {id_pc4[31:28], id_index, 2'b00};
        if (con_jump == 2'b10) return id_rs;
        return id_pc4 + off;
    endfunction

    always @(posedge clk) begin
        bit          r, req;
        logic [31:0] t;
        r   = m_redir();
        t   = m_target();
        req = m_started && (m_outst || !stall);
        if (!rst_n) begin
            m_valid = 1; m_started = 0; m_outst = 0; m_pend = 0;
            m_pc = 32'h0; m_pc4 = 32'h4; m_flush = 0;
        end else if (m_valid) begin
            if (!m_started) begin
                m_started = 1;
                if (r) m_pc = t;
            end else if (req && imem_ready) begin
                m_pc4  = m_pc + 4;
                m_pc   = m_pend ? m_ptgt : (r ? t : m_pc + 4);
                m_pend = 0;
                m_outst = 0;
            end else if (req) begin
                if (m_outst) begin
                    if (r) begin m_pend = 1; m_ptgt = t; end
                end else begin
                    m_outst = 1;
                    if (r) m_pc = t;
                end
            end
            m_flush = r;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("req",      32'(imem_req), 32'(m_started && (m_outst || !stall)));
            check("addr",     imem_addr, m_pc);
            check("pc4",      pc4, m_pc4);
            check("flush",    32'(flush), 32'(m_flush));
            check("redirect", 32'(redirect), 32'(m_redir()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic [1:0] j, input logic [2:0] b, input logic [31:0] p4,
                            input logic [15:0] imm, input logic [25:0] idx,
                            input logic [31:0] rs, input logic [31:0] rt);
        con_jump = j; con_bop = b; id_pc4 = p4; id_imm = imm;
        id_index = idx; id_rs = rs; id_rt = rt;
    endtask

    task automatic clear_ctrl();
        con_jump = 2'b00; con_bop = 3'b000;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        set_ctrl(2'b00, 3'b000, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);
        step(); step();
        check("rst_req",   32'(imem_req), 32'h0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_pc4",   pc4, 32'h4);
        check("rst_flush", 32'(flush), 32'h0);

        // sequential fetch after the idle cycle
        rst_n = 1'b1;
        step();
        check("seq0_addr", imem_addr, 32'h0);
        check("seq0_req",  32'(imem_req), 32'h1);
        step();
        check("seq1_addr", imem_addr, 32'h4);
        step();
        check("seq2_addr", imem_addr, 32'h8);
        check("seq_flush", 32'(flush), 32'h0);

        // beq taken then not taken
        set_ctrl(2'b00, 3'b001, 32'h100, 16'hFFFE, 26'h0, 32'd5, 32'd5);
        #1 check("beq_redir", 32'(redirect), 32'h1);
        step(); clear_ctrl();
        check("beq_addr",  imem_addr, 32'hF8);
        check("beq_flush", 32'(flush), 32'h1);
        step();
        check("beq_flush_off", 32'(flush), 32'h0);
        check("beq_next",      imem_addr, 32'hFC);
        set_ctrl(2'b00, 3'b001, 32'h100, 16'hFFFE, 26'h0, 32'd5, 32'd6);
        #1 check("beqn_redir", 32'(redirect), 32'h0);
        step(); clear_ctrl();
        check("beqn_addr", imem_addr, 32'h100);

        // j and jr
        set_ctrl(2'b01, 3'b000, 32'h1000_0040, 16'h0, 26'h10, 32'h0, 32'h0);
        step(); clear_ctrl();
        check("j_addr", imem_addr, 32'h1000_0040);
        set_ctrl(2'b10, 3'b000, 32'h0, 16'h0, 26'h0, 32'hDEAD_BEE0, 32'h0);
        step(); clear_ctrl();
        check("jr_addr", imem_addr, 32'hDEAD_BEE0);

        // imem not ready for three cycles, bne taken while waiting
        imem_ready = 1'b0;
        step();
        check("wait_addr1", imem_addr, 32'hDEAD_BEE0);
        check("wait_req",   32'(imem_req), 32'h1);
        set_ctrl(2'b00, 3'b010, 32'h100, 16'h0040, 26'h0, 32'd1, 32'd2);
        step(); clear_ctrl();
        check("wait_addr2", imem_addr, 32'hDEAD_BEE0);
        check("wait_flush", 32'(flush), 32'h1);
        step();
        check("wait_addr3",     imem_addr, 32'hDEAD_BEE0);
        check("wait_flush_off", 32'(flush), 32'h0);
        imem_ready = 1'b1;
        step();
        check("wait_tgt",   imem_addr, 32'h200);
        check("wait_flush2", 32'(flush), 32'h0);

        // stall beats a simultaneous jump; jump applies once stall drops
        stall = 1'b1;
        set_ctrl(2'b01, 3'b000, 32'h1000_0040, 16'h0, 26'h20, 32'h0, 32'h0);
        #1;
        check("stall_req",   32'(imem_req), 32'h0);
        check("stall_redir", 32'(redirect), 32'h0);
        step();
        check("stall_addr",  imem_addr, 32'h200);
        check("stall_flush", 32'(flush), 32'h0);
        stall = 1'b0;
        step(); clear_ctrl();
        check("unstall_addr",  imem_addr, 32'h1000_0080);
        check("unstall_flush", 32'(flush), 32'h1);

        // bltz on a negative rs
        set_ctrl(2'b00, 3'b101, 32'h300, 16'h0004, 26'h0, 32'hFFFF_FFFF, 32'h0);
        #1 check("bltz_redir", 32'(redirect), 32'(ZERO_EN));
        step(); clear_ctrl();
        check("bltz_addr", imem_addr, ZERO_EN ? 32'h310 : 32'h1000_0084);

        // reset while a request is outstanding
        imem_ready = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        check("rstw_req",  32'(imem_req), 32'h0);
        check("rstw_addr", imem_addr, 32'h0);
        rst_n = 1'b1; imem_ready = 1'b1;
        step();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            stall      = ($urandom_range(0, 4) == 0);
            imem_ready = ($urandom_range(0, 9) < 7);
            con_jump   = 2'($urandom);
            con_bop    = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            if (con_jump != 2'b00 && $urandom_range(0, 1) == 0) con_jump = 2'b00;
            id_pc4     = $urandom & 32'hFFFF_FFFC;
            id_imm     = 16'($urandom);
            id_index   = 26'($urandom);
            id_rs      = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) - 32'd2 : $urandom;
            id_rt      = ($urandom_range(0, 1) == 0) ? id_rs : $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
